// File: rtl/piso_dot_product_ctrl.sv
// Sequencer for an N-word PISO stage: loads it, shifts it out word by word,
// and accumulates the dot product of the words with captured coefficients.
module piso_dot_product_ctrl #(
    parameter int DW = 16,
    parameter int CW = 16,
    parameter int N  = 8,
    parameter int AW = DW + CW + 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] c0,
    input  logic [CW-1:0] c1,
    input  logic [CW-1:0] c2,
    input  logic [CW-1:0] c3,
    input  logic [CW-1:0] c4,
    input  logic [CW-1:0] c5,
    input  logic [CW-1:0] c6,
    input  logic [CW-1:0] c7,
    input  logic [DW-1:0] piso_out,
    output logic          piso_sel,
    output logic          piso_en,
    output logic          busy,
    output logic [AW-1:0] result,
    output logic          result_valid
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] ACC  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    acc_next;
    logic [DW+CW-1:0] prod;
    logic [CW-1:0]    creg [N];
    logic [CW-1:0]    cin  [N];
    logic             last;
    logic             take;

    assign cin[0] = c0;
    assign cin[1] = c1;
    assign cin[2] = c2;
    assign cin[3] = c3;
    assign cin[4] = c4;
    assign cin[5] = c5;
    assign cin[6] = c6;
    assign cin[7] = c7;

    assign last     = (idx == IW'(N - 1));
    assign take     = start && (state == IDLE || state == DONE);
    assign prod     = {{CW{1'b0}}, piso_out} * {{DW{1'b0}}, creg[idx]};
    assign acc_next = acc + AW'(prod);

    // Control outputs depend only on registered state, never on start.
    assign piso_sel     = (state == LOAD);
    assign piso_en      = (state == ACC) && !last;
    assign busy         = (state == LOAD) || (state == ACC);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            result <= '0;
            for (int i = 0; i < N; i++) creg[i] <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (take) begin
                        state <= LOAD;
                        for (int i = 0; i < N; i++) creg[i] <= cin[i];
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    acc   <= '0;
                    idx   <= '0;
                    state <= ACC;
                end
                ACC: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (last) begin
                        result <= acc_next;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_dot_product_ctrl.sv
// Directed bench: a behavioural 8-word PISO feeds the controller; results
// are compared against hand-computed dot products.
module tb_piso_dot_product_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cv [8];
    logic [15:0] xv [8];
    logic [15:0] sr [8];
    logic [15:0] piso_out;
    logic        piso_sel, piso_en, busy, result_valid;
    logic [34:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    piso_dot_product_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .c0(cv[0]), .c1(cv[1]), .c2(cv[2]), .c3(cv[3]),
        .c4(cv[4]), .c5(cv[5]), .c6(cv[6]), .c7(cv[7]),
        .piso_out(piso_out), .piso_sel(piso_sel), .piso_en(piso_en),
        .busy(busy), .result(result), .result_valid(result_valid)
    );

    // PISO stage: load puts x0 on the output next cycle, shift advances.
    always_ff @(posedge clk) begin
        if (piso_sel) begin
            for (int i = 0; i < 8; i++) sr[i] <= xv[i];
        end else if (piso_en) begin
            for (int i = 0; i < 7; i++) sr[i] <= sr[i+1];
            sr[7] <= '0;
        end
    end
    assign piso_out = sr[0];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_frame(input string tag, input logic [63:0] exp, input bit scramble);
        int vcyc, vcnt, nsel, nen;
        logic [63:0] res;
        vcyc = -1; vcnt = 0; nsel = 0; nen = 0; res = '0;
        @(posedge clk); #1 start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
            if (scramble && cyc == 4)
                for (int k = 0; k < 8; k++) cv[k] = 16'(k * 977 + 3);
            nsel += int'(piso_sel);
            nen  += int'(piso_en);
            if (result_valid) begin
                if (vcyc < 0) vcyc = cyc;
                vcnt++;
                res = 64'(result);
            end
        end
        chk({tag, "_lat"},    64'(vcyc), 64'd10);
        chk({tag, "_vcnt"},   64'(vcnt), 64'd1);
        chk({tag, "_result"}, res,       exp);
        chk({tag, "_sel"},    64'(nsel), 64'd1);
        chk({tag, "_en"},     64'(nen),  64'd7);
    endtask

    initial begin
        int v1, v2, vcnt, nbusy_lo, nidle;
        logic [34:0] held;
        rst = 1'b1; start = 1'b0;
        for (int k = 0; k < 8; k++) begin xv[k] = 16'(k + 1); cv[k] = 16'd1; end
        #3;
        chk("rst_busy",  64'(busy),         64'd0);
        chk("rst_sel",   64'(piso_sel),     64'd0);
        chk("rst_en",    64'(piso_en),      64'd0);
        chk("rst_valid", 64'(result_valid), 64'd0);
        chk("rst_result", 64'(result),      64'd0);
        @(negedge clk); rst = 1'b0;

        run_frame("ones", 64'd36, 1'b0);

        for (int k = 0; k < 8; k++) cv[k] = 16'(k + 1);
        run_frame("weights", 64'd204, 1'b1);

        for (int k = 0; k < 8; k++) begin xv[k] = 16'hFFFF; cv[k] = 16'hFFFF; end
        run_frame("max", 64'h7_FFF0_0008, 1'b0);

        held = result; nidle = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (result !== held || result_valid || piso_sel || piso_en || busy) nidle++;
        end
        chk("idle_ctl",    64'(nidle),  64'd0);
        chk("idle_result", 64'(result), 64'h7_FFF0_0008);

        // Back-to-back: start held 25 cycles.
        for (int k = 0; k < 8; k++) begin xv[k] = 16'(k + 1); cv[k] = 16'd1; end
        v1 = -1; v2 = -1; vcnt = 0; nbusy_lo = 0;
        @(posedge clk); #1 start = 1'b1;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 25) start = 1'b0;
            if (cyc <= 29) begin
                if (!busy) nbusy_lo++;
                if (result_valid) begin
                    vcnt++;
                    if (v1 < 0) v1 = cyc; else if (v2 < 0) v2 = cyc;
                end
            end
        end
        chk("b2b_vcnt",   64'(vcnt),     64'd2);
        chk("b2b_v1",     64'(v1),       64'd10);
        chk("b2b_v2",     64'(v2),       64'd20);
        chk("b2b_busylo", 64'(nbusy_lo), 64'd2);
        chk("b2b_result", 64'(result),   64'd36);
        @(posedge clk); #1;

        // Reset during ACC with idx=4 (cycle 6 of the frame).
        @(posedge clk); #1 start = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
        end
        chk("mid_busy_pre", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy",   64'(busy),         64'd0);
        chk("mid_sel",    64'(piso_sel),     64'd0);
        chk("mid_en",     64'(piso_en),      64'd0);
        chk("mid_valid",  64'(result_valid), 64'd0);
        chk("mid_result", 64'(result),       64'd0);
        @(negedge clk); rst = 1'b0;
        run_frame("post_rst", 64'd36, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_dot_product_ctrl.md
Name: piso_dot_product_ctrl

Overview:
- Downstream consumer and sequencer for the 8-word, 16-bit parallel-in/serial-out shift stage.
- Drives that stage's load select and shift enable, consumes its serial word output, and computes a dot product of the 8 words with 8 coefficients.
- Coefficients are captured at start; the result is presented with a one-cycle valid pulse.
- Sits between the PISO stage and the downstream result sink (register file / display logic).

Parameters:
- DW, 16, width of each data word from the PISO stage.
- CW, 16, width of each coefficient.
- N, 8, number of words per frame; must match PISO depth.
- AW, DW+CW+3, accumulator/result width (3 = clog2(N)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, active-high. Asynchronous assert.
- start  input  1  request one frame computation; sampled only in IDLE or DONE.
- c0..c7  input  CW each  unsigned coefficients; c0 multiplies first word out of the PISO.
- piso_out  input  DW  serial word from the PISO output.
- piso_sel  output  1  PISO load select (1 = parallel load).
- piso_en  output  1  PISO shift enable (en1).
- busy  output  1  high in LOAD and ACC.
- result  output  AW  unsigned dot product of the last completed frame.
- result_valid  output  1  one-cycle pulse when result updates.

Behaviour:
- Reset (async, rst=1): state=IDLE; piso_sel=0, piso_en=0, busy=0, result=0, result_valid=0, idx=0, acc=0, coefficient regs=0.
- PISO contract: a load edge makes piso_out=x0 from the next cycle. Each shift edge advances piso_out x0, x1, ..., x7.
- FSM states: IDLE, LOAD, ACC, DONE. All outputs are registered or decoded from state only; no combinational path from start.
- IDLE: all control outputs 0. start=1 -> LOAD at next edge; capture c0..c7 into internal regs at that edge.
- LOAD (1 cycle): piso_sel=1, piso_en=0, busy=1; acc<=0, idx<=0. -> ACC.
- ACC (N cycles, idx 0..N-1): busy=1, piso_sel=0.
  - acc <= acc + piso_out * creg[idx] (full-width unsigned, DW+CW product, zero-extended to AW; no overflow possible).
  - piso_en=1 when idx<N-1, 0 when idx=N-1, so the PISO does not shift past x7.
  - idx<=idx+1. After the idx=N-1 edge -> DONE.
- DONE (1 cycle): result <= final acc (written at the ACC->DONE edge); result_valid=1; busy=0.
  - start=1 -> LOAD (back-to-back frame; recapture coefficients).
  - else -> IDLE.
- Latency: start high in cycle 0 -> LOAD in cycle 1 -> ACC in cycles 2..9 -> result_valid in cycle 10. Throughput is one frame per 10 cycles with start held.
- start in LOAD/ACC is ignored; no queuing.
- Coefficient input changes after capture have no effect on the frame in flight.
- result holds its value until the next DONE; it is not cleared in IDLE.
- Reset mid-frame: immediate return to IDLE with reset values; partial acc is discarded, result is cleared to 0, no valid pulse.
- Exactly one ACC accumulation per word. Total piso_sel-high cycles per frame = 1; total piso_en-high cycles per frame = N-1.

Test Plan:
- Bench: real PISO stage + this block, x0..x7=1..8, c0..c7=1, pulse start -> result_valid in cycle 10, result=36; piso_sel high 1 cycle, piso_en high 7 cycles.
- Weights: x0..x7=1..8, ck=k+1 -> result=204 (1²+…+8²); change c inputs during ACC -> result still 204.
- Max values: all x=0xFFFF, all c=0xFFFF -> result=0x7FFF00008 (35 bits, no wrap).
- Back-to-back: start held high for 25 cycles -> two frames, valid pulses in cycles 10 and 20, busy low only in DONE cycles; the extra start in LOAD/ACC does not create a third overlapping frame.
- Reset mid-frame: assert rst during ACC idx=4 -> all outputs 0 asynchronously; after release with start -> a clean frame gives the correct result (36 for the first stimulus).
- Idle hold: no start for 20 cycles after a frame -> result stable, result_valid=0, piso_sel=piso_en=0.
